// File: rtl/gmii_mii_speed_adapter.sv
`default_nettype none
// ============================================================================
// gmii_mii_speed_adapter: tri-speed MAC<->PHY adapter on a single 125 MHz clk.
// Rev 1.0 - initial release
// ============================================================================
module gmii_mii_speed_adapter #(
    parameter int CLK_DIV_100 = 5,
    parameter int CLK_DIV_10  = 50,
    parameter int CNT_W       = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] speed,
    input  logic [7:0] mac_txd,
    input  logic       mac_tx_en,
    input  logic       mac_tx_er,
    output logic       mac_tx_ready,
    output logic [7:0] mac_rxd,
    output logic       mac_rx_dv,
    output logic       mac_rx_er,
    output logic       mac_rx_valid,
    input  logic [7:0] phy_rxd,
    input  logic       phy_rx_dv,
    input  logic       phy_rx_er,
    output logic [7:0] phy_txd,
    output logic       phy_tx_en,
    output logic       phy_tx_er,
    output logic       phy_ce
);
    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_LO   = 2'd1,
        TX_HI   = 2'd2
    } tx_state_t;

    logic [1:0]       speed_q;
    logic             run_q;
    logic             phy_ce_q;
    logic [CNT_W-1:0] ce_cnt_q, ce_cnt_d;
    logic [CNT_W-1:0] div_m1;
    logic             gig, speed_chg, ce, tx_ready;

    tx_state_t  tx_state_q, tx_state_d;
    logic [7:0] phy_txd_q, phy_txd_d;
    logic       phy_tx_en_q, phy_tx_en_d;
    logic       phy_tx_er_q, phy_tx_er_d;
    logic [3:0] tx_hi_q, tx_hi_d;

    logic [3:0] rx_lo_q, rx_lo_d;
    logic       rx_er_lo_q, rx_er_lo_d;
    logic       rx_phase_q, rx_phase_d;
    logic       rx_idle_q, rx_idle_d;
    logic [7:0] mac_rxd_q, mac_rxd_d;
    logic       mac_rx_dv_q, mac_rx_dv_d;
    logic       mac_rx_er_q, mac_rx_er_d;
    logic       mac_rx_valid_q, mac_rx_valid_d;

    assign gig       = speed_q[1];
    assign speed_chg = (speed != speed_q);
    assign div_m1    = (speed_q == 2'd0) ? CNT_W'(CLK_DIV_10 - 1) : CNT_W'(CLK_DIV_100 - 1);
    assign ce        = gig | (ce_cnt_q == div_m1);
    // A speed change cycle never accepts a byte, so the MAC must hold it.
    assign tx_ready  = run_q & ~speed_chg & (gig | (ce & (tx_state_q != TX_LO)));

    always_comb begin
        ce_cnt_d = ce_cnt_q + CNT_W'(1);
        if (speed_chg || ce) begin
            ce_cnt_d = '0;
        end
    end

    always_comb begin
        tx_state_d  = tx_state_q;
        phy_txd_d   = phy_txd_q;
        phy_tx_en_d = phy_tx_en_q;
        phy_tx_er_d = phy_tx_er_q;
        tx_hi_d     = tx_hi_q;
        if (speed_chg) begin
            tx_state_d  = TX_IDLE;
            phy_tx_en_d = 1'b0;
            phy_tx_er_d = 1'b0;
        end else if (gig) begin
            tx_state_d  = TX_IDLE;
            phy_txd_d   = mac_txd;
            phy_tx_en_d = mac_tx_en;
            phy_tx_er_d = mac_tx_er;
        end else if (tx_ready) begin
            tx_state_d  = TX_LO;
            phy_txd_d   = {4'h0, mac_txd[3:0]};
            phy_tx_en_d = mac_tx_en;
            phy_tx_er_d = mac_tx_er;
            tx_hi_d     = mac_txd[7:4];
        end else if (ce && (tx_state_q == TX_LO)) begin
            tx_state_d  = TX_HI;
            phy_txd_d   = {4'h0, tx_hi_q};
        end
    end

    always_comb begin
        rx_lo_d        = rx_lo_q;
        rx_er_lo_d     = rx_er_lo_q;
        rx_phase_d     = rx_phase_q;
        rx_idle_d      = rx_idle_q;
        mac_rxd_d      = mac_rxd_q;
        mac_rx_dv_d    = mac_rx_dv_q;
        mac_rx_er_d    = mac_rx_er_q;
        mac_rx_valid_d = 1'b0;
        if (speed_chg) begin
            rx_lo_d    = 4'h0;
            rx_er_lo_d = 1'b0;
            rx_phase_d = 1'b0;
            rx_idle_d  = 1'b0;
        end else if (gig) begin
            mac_rxd_d      = phy_rxd;
            mac_rx_dv_d    = phy_rx_dv;
            mac_rx_er_d    = phy_rx_er;
            mac_rx_valid_d = 1'b1;
            rx_phase_d     = 1'b0;
            rx_idle_d      = 1'b0;
        end else if (ce) begin
            if (phy_rx_dv) begin
                rx_idle_d = 1'b0;
                if (!rx_phase_q) begin
                    rx_lo_d    = phy_rxd[3:0];
                    rx_er_lo_d = phy_rx_er;
                    rx_phase_d = 1'b1;
                end else begin
                    mac_rxd_d      = {phy_rxd[3:0], rx_lo_q};
                    mac_rx_dv_d    = 1'b1;
                    mac_rx_er_d    = rx_er_lo_q | phy_rx_er;
                    mac_rx_valid_d = 1'b1;
                    rx_phase_d     = 1'b0;
                end
            end else if (rx_phase_q) begin
                // Frame ended on an odd nibble: flush it as an alignment error.
                mac_rxd_d      = {4'h0, rx_lo_q};
                mac_rx_dv_d    = 1'b1;
                mac_rx_er_d    = 1'b1;
                mac_rx_valid_d = 1'b1;
                rx_phase_d     = 1'b0;
                rx_idle_d      = 1'b0;
            end else begin
                rx_idle_d = ~rx_idle_q;
                if (rx_idle_q) begin
                    mac_rx_dv_d    = 1'b0;
                    mac_rx_er_d    = phy_rx_er;
                    mac_rx_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        speed_q <= speed;
        if (!rst_n) begin
            run_q          <= 1'b0;
            phy_ce_q       <= 1'b0;
            ce_cnt_q       <= '0;
            tx_state_q     <= TX_IDLE;
            phy_txd_q      <= 8'h00;
            phy_tx_en_q    <= 1'b0;
            phy_tx_er_q    <= 1'b0;
            tx_hi_q        <= 4'h0;
            rx_lo_q        <= 4'h0;
            rx_er_lo_q     <= 1'b0;
            rx_phase_q     <= 1'b0;
            rx_idle_q      <= 1'b0;
            mac_rxd_q      <= 8'h00;
            mac_rx_dv_q    <= 1'b0;
            mac_rx_er_q    <= 1'b0;
            mac_rx_valid_q <= 1'b0;
        end else begin
            run_q          <= 1'b1;
            phy_ce_q       <= ce;
            ce_cnt_q       <= ce_cnt_d;
            tx_state_q     <= tx_state_d;
            phy_txd_q      <= phy_txd_d;
            phy_tx_en_q    <= phy_tx_en_d;
            phy_tx_er_q    <= phy_tx_er_d;
            tx_hi_q        <= tx_hi_d;
            rx_lo_q        <= rx_lo_d;
            rx_er_lo_q     <= rx_er_lo_d;
            rx_phase_q     <= rx_phase_d;
            rx_idle_q      <= rx_idle_d;
            mac_rxd_q      <= mac_rxd_d;
            mac_rx_dv_q    <= mac_rx_dv_d;
            mac_rx_er_q    <= mac_rx_er_d;
            mac_rx_valid_q <= mac_rx_valid_d;
        end
    end

    assign mac_tx_ready = tx_ready;
    assign mac_rxd      = mac_rxd_q;
    assign mac_rx_dv    = mac_rx_dv_q;
    assign mac_rx_er    = mac_rx_er_q;
    assign mac_rx_valid = mac_rx_valid_q;
    assign phy_txd      = phy_txd_q;
    assign phy_tx_en    = phy_tx_en_q;
    assign phy_tx_er    = phy_tx_er_q;
    assign phy_ce       = phy_ce_q;

endmodule
`default_nettype wire

// File: tb/tb_gmii_mii_speed_adapter.sv
`default_nettype none
// ============================================================================
// tb_gmii_mii_speed_adapter: random tri-speed traffic against a byte/nibble model.
// Rev 1.0 - initial release
// ============================================================================
module tb_gmii_mii_speed_adapter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] speed;
    logic [7:0] mac_txd;
    logic       mac_tx_en, mac_tx_er;
    logic       mac_tx_ready;
    logic [7:0] mac_rxd;
    logic       mac_rx_dv, mac_rx_er, mac_rx_valid;
    logic [7:0] phy_rxd;
    logic       phy_rx_dv, phy_rx_er;
    logic [7:0] phy_txd;
    logic       phy_tx_en, phy_tx_er, phy_ce;

    typedef struct packed { logic [7:0] d; logic en; logic er; } tx_item_t;
    typedef struct packed { logic [3:0] nib; logic dv; logic er; } rx_nib_t;
    typedef struct packed { logic [7:0] d; logic er; } rx_byte_t;

    tx_item_t tx_q[$];
    rx_nib_t  rx_sched[$];
    rx_byte_t rx_exp[$];
    int n_checks = 0;
    int n_fail   = 0;

    gmii_mii_speed_adapter #(.CLK_DIV_100(5), .CLK_DIV_10(50), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .speed(speed),
        .mac_txd(mac_txd), .mac_tx_en(mac_tx_en), .mac_tx_er(mac_tx_er),
        .mac_tx_ready(mac_tx_ready),
        .mac_rxd(mac_rxd), .mac_rx_dv(mac_rx_dv), .mac_rx_er(mac_rx_er),
        .mac_rx_valid(mac_rx_valid),
        .phy_rxd(phy_rxd), .phy_rx_dv(phy_rx_dv), .phy_rx_er(phy_rx_er),
        .phy_txd(phy_txd), .phy_tx_en(phy_tx_en), .phy_tx_er(phy_tx_er),
        .phy_ce(phy_ce)
    );

    always #4 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected bytes come from pairing nibbles low-first; a lone trailing nibble is an alignment error.
    task automatic add_frame(input logic [31:0] nibs, input int len, input logic [7:0] ers);
        for (int i = 0; i < len; i++)
            rx_sched.push_back('{nib: nibs[4*i +: 4], dv: 1'b1, er: ers[i]});
        for (int i = 0; i < len; i += 2) begin
            if (i + 1 < len)
                rx_exp.push_back('{d: {nibs[4*i+4 +: 4], nibs[4*i +: 4]}, er: ers[i] | ers[i+1]});
            else
                rx_exp.push_back('{d: {4'h0, nibs[4*i +: 4]}, er: 1'b1});
        end
        repeat (2) rx_sched.push_back('{nib: 4'h0, dv: 1'b0, er: 1'b0});
    endtask

    task automatic add_random_frames(input int n);
        for (int i = 0; i < n; i++)
            add_frame($urandom, int'($urandom_range(1, 6)),
                      ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
    endtask

    task automatic run_gig(input int n);
        logic [7:0] td, rd;
        logic       te, tr, rv, re;
        for (int i = 0; i < n; i++) begin
            case (i)
                0:       td = 8'h55;
                1:       td = 8'hD5;
                2:       td = 8'hA3;
                default: td = 8'($urandom);
            endcase
            te = (i < 3) ? 1'b1 : 1'($urandom);
            tr = (i < 3) ? 1'b0 : ($urandom_range(0, 7) == 0);
            rd = (i < 3) ? td : 8'($urandom);
            rv = (i < 3) ? 1'b1 : 1'($urandom);
            re = (i < 3) ? 1'b0 : ($urandom_range(0, 7) == 0);
            mac_txd = td; mac_tx_en = te; mac_tx_er = tr;
            phy_rxd = rd; phy_rx_dv = rv; phy_rx_er = re;
            @(negedge clk);
            check("gig_phy_txd", 32'(phy_txd), 32'(td));
            check("gig_phy_tx_en", 32'(phy_tx_en), 32'(te));
            check("gig_phy_tx_er", 32'(phy_tx_er), 32'(tr));
            check("gig_mac_rxd", 32'(mac_rxd), 32'(rd));
            check("gig_mac_rx_dv", 32'(mac_rx_dv), 32'(rv));
            check("gig_mac_rx_er", 32'(mac_rx_er), 32'(re));
            check("gig_mac_rx_valid", 32'(mac_rx_valid), 32'd1);
            check("gig_tx_ready", 32'(mac_tx_ready), 32'd1);
            check("gig_phy_ce", 32'(phy_ce), 32'd1);
        end
    endtask

    // Caller has just changed speed to an MII rate; cycle 0 follows the change edge.
    task automatic run_mii(input int div, input logic [7:0] first_b, input bit do_switch);
        int       ncyc;
        bit       first, seen;
        logic     ce_now, ce_prev;
        tx_item_t it;
        rx_nib_t  nb;
        rx_byte_t eb;
        logic [7:0] b;
        ncyc  = (rx_sched.size() + 3) * div;
        first = 1'b1;
        tx_q.delete();
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            ce_now  = ((k % div) == div - 1);
            ce_prev = (k > 0) && (((k - 1) % div) == div - 1);
            if (k > 0) check("mii_phy_ce", 32'(phy_ce), 32'(ce_prev));
            if (!ce_prev) check("mii_rx_valid_gap", 32'(mac_rx_valid), 32'd0);
            if (mac_rx_valid && mac_rx_dv) begin
                check("mii_rx_pending", 32'(rx_exp.size() > 0), 32'd1);
                if (rx_exp.size() > 0) begin
                    eb = rx_exp.pop_front();
                    check("mii_rx_byte", 32'(mac_rxd), 32'(eb.d));
                    check("mii_rx_er", 32'(mac_rx_er), 32'(eb.er));
                end
            end
            if (tx_q.size() > 0) begin
                it = tx_q.pop_front();
                check("mii_tx_en", 32'(phy_tx_en), 32'(it.en));
                check("mii_tx_er", 32'(phy_tx_er), 32'(it.er));
                if (it.en) check("mii_tx_nibble", 32'(phy_txd), 32'(it.d));
            end else begin
                check("mii_tx_idle_en", 32'(phy_tx_en), 32'd0);
            end
            check("mii_tx_ready", 32'(mac_tx_ready), 32'(ce_now && (tx_q.size() == 0)));
            if (mac_tx_ready) begin
                b         = first ? first_b : 8'($urandom);
                mac_tx_en = first ? 1'b1 : ($urandom_range(0, 3) != 0);
                mac_tx_er = first ? 1'b0 : ($urandom_range(0, 7) == 0);
                mac_txd   = b;
                first     = 1'b0;
                for (int j = 0; j < div; j++)
                    tx_q.push_back('{d: {4'h0, b[3:0]}, en: mac_tx_en, er: mac_tx_er});
                for (int j = 0; j < div; j++)
                    tx_q.push_back('{d: {4'h0, b[7:4]}, en: mac_tx_en, er: mac_tx_er});
            end
            if (ce_now) begin
                nb = (rx_sched.size() > 0) ? rx_sched.pop_front() : '{nib: 4'h0, dv: 1'b0, er: 1'b0};
                phy_rxd = {4'($urandom), nb.nib}; phy_rx_dv = nb.dv; phy_rx_er = nb.er;
            end else begin
                phy_rxd = 8'($urandom); phy_rx_dv = 1'($urandom); phy_rx_er = 1'($urandom);
            end
        end
        check("mii_rx_drained", 32'(rx_exp.size()), 32'd0);
        if (do_switch) begin
            phy_rx_dv = 1'b0; phy_rx_er = 1'b0;
            seen = 1'b0;
            for (int j = 0; j < 4 * div && !seen; j++) begin
                @(negedge clk);
                if (mac_tx_ready) begin
                    seen = 1'b1;
                    mac_txd = 8'($urandom); mac_tx_en = 1'b1; mac_tx_er = 1'b0;
                end
            end
            check("switch_ready_seen", 32'(seen), 32'd1);
            @(negedge clk);
            check("switch_pre_en", 32'(phy_tx_en), 32'd1);
            speed = 2'd2; mac_txd = 8'hC3; mac_tx_en = 1'b1; mac_tx_er = 1'b1;
            @(negedge clk);
            check("switch_tx_en", 32'(phy_tx_en), 32'd0);
            check("switch_tx_er", 32'(phy_tx_er), 32'd0);
            mac_txd = 8'h5A; mac_tx_en = 1'b1; mac_tx_er = 1'b1;
            @(negedge clk);
            check("switch_passthru_d", 32'(phy_txd), 32'h5A);
            check("switch_passthru_en", 32'(phy_tx_en), 32'd1);
            check("switch_passthru_er", 32'(phy_tx_er), 32'd1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        speed = 2'($urandom);
        mac_txd = 8'($urandom); mac_tx_en = 1'b1; mac_tx_er = 1'b1;
        phy_rxd = 8'($urandom); phy_rx_dv = 1'b1; phy_rx_er = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_outputs_zero",
                  32'({mac_tx_ready, mac_rxd, mac_rx_dv, mac_rx_er, mac_rx_valid,
                       phy_txd, phy_tx_en, phy_tx_er, phy_ce}), 32'd0);
            mac_txd = 8'($urandom); mac_tx_en = 1'($urandom); mac_tx_er = 1'($urandom);
            phy_rxd = 8'($urandom); phy_rx_dv = 1'($urandom); phy_rx_er = 1'($urandom);
            speed = (i == 0) ? 2'($urandom) : 2'd2;
            if (i == 2) rst_n = 1'b1;
        end
        @(negedge clk);
        check("release_tx_ready", 32'(mac_tx_ready), 32'd1);

        run_gig(12);

        speed = 2'd1;
        add_frame(32'h0000_0721, 3, 8'h00);
        add_random_frames(3);
        run_mii(5, 8'hA3, 1'b1);

        run_gig(8);

        speed = 2'd0;
        add_frame(32'h0000_D555, 4, 8'h00);
        add_random_frames(1);
        run_mii(50, 8'h3C, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
